// File: rtl/chronos_mem_pkg.sv
// Shared constants and helpers for the chronos memory arbiter slice.
package chronos_mem_pkg;

    // Originator tag stored per outstanding backend request.
    typedef enum logic {
        TAG_IMEM = 1'b0,
        TAG_DMEM = 1'b1
    } mem_tag_e;

    localparam logic MEM_RW_READ  = 1'b0;
    localparam logic MEM_RW_WRITE = 1'b1;

    // Unlocked arbitration: a lone requester wins; with both pending dmem
    // wins unless imem has been starved up to the limit.
    function automatic mem_tag_e arb_pick(
        input logic imem_val,
        input logic dmem_val,
        input logic starved
    );
        mem_tag_e pick;
        if (imem_val && !dmem_val) begin
            pick = TAG_IMEM;
        end else if (!imem_val && dmem_val) begin
            pick = TAG_DMEM;
        end else if (imem_val && dmem_val && starved) begin
            pick = TAG_IMEM;
        end else begin
            pick = TAG_DMEM;
        end
        return pick;
    endfunction

endpackage

// File: rtl/chronos_tag_fifo.sv
// In-order tag FIFO: remembers which requester owns each outstanding
// backend transaction so responses can be routed back in order.
module chronos_tag_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Guarded handshakes: a push into a full FIFO or a pop of an empty one is ignored.
    always_comb begin
        full      = (count_r == CW'(DEPTH));
        empty     = (count_r == {CW{1'b0}});
        push_ok_s = push && !full;
        pop_ok_s  = pop && !empty;
        head      = mem_r[rd_ptr_r];
    end

    // Storage write at the tail.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_r <= '{default: '0};
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end else begin
            mem_r <= mem_r;
        end
    end

    // Wrapping read/write pointers and occupancy count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= (wr_ptr_r == AW'(DEPTH - 1)) ? {AW{1'b0}} : wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= (rd_ptr_r == AW'(DEPTH - 1)) ? {AW{1'b0}} : rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/chronos_mem_arbiter.sv
// Shares one backend memory port between instruction fetch (imem) and
// data (dmem) streams: dmem priority, imem anti-starvation, grant lock
// while the backend stalls, and in-order response routing via a tag FIFO.
module chronos_mem_arbiter
    import chronos_mem_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imem_req_val,
    input  logic [ADDR_W-1:0] imem_req_addr,
    output logic              imem_req_rdy,
    output logic              imem_resp_val,
    output logic [DATA_W-1:0] imem_resp_data,
    input  logic              dmem_req_val,
    input  logic              dmem_req_rw,
    input  logic [ADDR_W-1:0] dmem_req_addr,
    input  logic [DATA_W-1:0] dmem_req_wdata,
    output logic              dmem_req_rdy,
    output logic              dmem_resp_val,
    output logic [DATA_W-1:0] dmem_resp_data,
    output logic              mem_req_val,
    output logic              mem_req_rw,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_req_rdy,
    input  logic              mem_resp_val,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic              err
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic          lock_r;
    mem_tag_e      lock_tag_r;
    logic [SW-1:0] starve_cnt_r;
    logic          err_r;

    mem_tag_e      grant_s;
    logic          starved_s;
    logic          granted_val_s;
    logic          accept_s;
    logic          pop_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic          fifo_head_s;
    mem_tag_e      head_tag_s;

    chronos_tag_fifo #(
        .WIDTH (1),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept_s),
        .push_data (grant_s),
        .pop       (pop_s),
        .head      (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Grant selection: a stalled request keeps its grant, otherwise arbitrate.
    always_comb begin
        starved_s = (starve_cnt_r == SW'(STARVE_LIMIT));
        if (lock_r) begin
            grant_s = lock_tag_r;
        end else begin
            grant_s = arb_pick(imem_req_val, dmem_req_val, starved_s);
        end
    end

    // Zero-latency request mux towards the backend; fetches are always reads.
    always_comb begin
        case (grant_s)
            TAG_IMEM: begin
                granted_val_s = imem_req_val;
                mem_req_rw    = MEM_RW_READ;
                mem_req_addr  = imem_req_addr;
                mem_req_wdata = {DATA_W{1'b0}};
            end
            TAG_DMEM: begin
                granted_val_s = dmem_req_val;
                mem_req_rw    = dmem_req_rw;
                mem_req_addr  = dmem_req_addr;
                mem_req_wdata = dmem_req_wdata;
            end
            default: begin
                granted_val_s = 1'b0;
                mem_req_rw    = MEM_RW_READ;
                mem_req_addr  = {ADDR_W{1'b0}};
                mem_req_wdata = {DATA_W{1'b0}};
            end
        endcase
    end

    // Handshakes and response routing; rst gating keeps every valid/ready low in reset.
    always_comb begin
        mem_req_val    = rst && granted_val_s && !fifo_full_s;
        accept_s       = mem_req_val && mem_req_rdy;
        imem_req_rdy   = accept_s && (grant_s == TAG_IMEM);
        dmem_req_rdy   = accept_s && (grant_s == TAG_DMEM);
        head_tag_s     = mem_tag_e'(fifo_head_s);
        pop_s          = rst && mem_resp_val && !fifo_empty_s;
        imem_resp_val  = pop_s && (head_tag_s == TAG_IMEM);
        dmem_resp_val  = pop_s && (head_tag_s == TAG_DMEM);
        imem_resp_data = mem_resp_data;
        dmem_resp_data = mem_resp_data;
        err            = err_r;
    end

    // Grant lock: hold the current grant while the backend refuses it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_r     <= 1'b0;
            lock_tag_r <= TAG_IMEM;
        end else if (mem_req_val && !mem_req_rdy) begin
            lock_r     <= 1'b1;
            lock_tag_r <= grant_s;
        end else begin
            lock_r     <= 1'b0;
            lock_tag_r <= lock_tag_r;
        end
    end

    // Anti-starvation counter: counts dmem wins while imem waits, saturating.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_r <= {SW{1'b0}};
        end else if (!imem_req_val || imem_req_rdy) begin
            starve_cnt_r <= {SW{1'b0}};
        end else if (dmem_req_rdy && !starved_s) begin
            starve_cnt_r <= starve_cnt_r + SW'(1);
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    // Sticky error: a backend response with nothing outstanding.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_r <= 1'b0;
        end else if (mem_resp_val && fifo_empty_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

endmodule
